pkt_drop_filter: RTL and testbench

PKT_DROP_FILTER -- requirements
Module: pkt_drop_filter

---
 rtl/rmt_drop_pkg.sv | 24 ++
 rtl/drop_sync_fifo.sv | 57 +++++
 rtl/pkt_drop_filter.sv | 135 +++++++++++++
 tb/tb_pkt_drop_filter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_drop_pkg.sv
// Shared constants and types for the packet drop filter.
package rmt_drop_pkg;

    localparam logic [1:0] MODE_NORMAL   = 2'b00;
    localparam logic [1:0] MODE_PASS_ALL = 2'b01;
    localparam logic [1:0] MODE_DROP_ALL = 2'b10;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_DROP
    } state_t;

    // Final drop verdict for a packet: drop-all overrides, pass-all suppresses.
    function automatic logic calc_eff_drop(input logic drop, input logic [1:0] md);
        logic r;
        r = drop && (md != MODE_PASS_ALL);
        if (md == MODE_DROP_ALL) r = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/drop_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty/level; pointers carry an extra
// wrap bit so full and empty are distinguishable.
module drop_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push, pop;

    // Guard push/pop against full/empty and advance pointers.
    always_comb begin
        push     = wr_en && !full;
        pop      = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/pkt_drop_filter.sv
// Buffers an AXI-stream and forwards or discards each packet according to an
// in-order per-packet decision stream, with pass/drop packet counters.
module pkt_drop_filter
    import rmt_drop_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned DATA_DEPTH           = 64,
    parameter int unsigned DEC_DEPTH            = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    input  logic                                s_axis_tlast,
    output logic                                s_axis_tready,
    input  logic                                dec_valid,
    input  logic                                dec_drop,
    output logic                                dec_ready,
    input  logic [1:0]                          mode,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_tready,
    output logic [CNT_W-1:0]                    pass_cnt,
    output logic [CNT_W-1:0]                    drop_cnt,
    output logic [$clog2(DATA_DEPTH):0]         data_level
);

    localparam int unsigned KW     = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned BEAT_W = C_S_AXIS_DATA_WIDTH + KW + C_S_AXIS_TUSER_WIDTH + 1;
    localparam int unsigned DLW    = $clog2(DEC_DEPTH) + 1;

    logic [BEAT_W-1:0]           beat_wr, beat_rd;
    logic                        beat_full, beat_empty, beat_pop;
    logic [$clog2(DATA_DEPTH):0] beat_level;
    logic                        dec_full, dec_empty, dec_pop, dec_rd, dec_avail;
    logic [DLW-1:0]              dec_level;
    logic                        m_valid;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign beat_wr = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};

    drop_sync_fifo #(.WIDTH(BEAT_W), .DEPTH(DATA_DEPTH)) u_beat_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s_axis_tvalid && s_axis_tready),
        .wr_data (beat_wr),
        .full    (beat_full),
        .rd_en   (beat_pop),
        .rd_data (beat_rd),
        .empty   (beat_empty),
        .level   (beat_level)
    );

    drop_sync_fifo #(.WIDTH(1), .DEPTH(DEC_DEPTH)) u_dec_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (dec_valid && dec_ready),
        .wr_data (dec_drop),
        .full    (dec_full),
        .rd_en   (dec_pop),
        .rd_data (dec_rd),
        .empty   (dec_empty),
        .level   (dec_level)
    );

    assign dec_avail = (dec_level != '0);

    // Output FSM: pick a verdict per packet in IDLE, then stream or discard
    // beats until the packet's tlast leaves the buffer.
    always_comb begin
        state_d    = state_q;
        pass_cnt_d = pass_cnt_q;
        drop_cnt_d = drop_cnt_q;
        beat_pop   = 1'b0;
        dec_pop    = 1'b0;
        m_valid    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!beat_empty && dec_avail)
                    state_d = calc_eff_drop(dec_rd, mode) ? ST_DROP : ST_FWD;
            end
            ST_FWD: begin
                m_valid  = !beat_empty;
                beat_pop = m_valid && m_axis_tready;
                if (beat_pop && beat_rd[0]) begin
                    dec_pop    = !dec_empty;
                    pass_cnt_d = pass_cnt_q + 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_DROP: begin
                beat_pop = !beat_empty;
                if (beat_pop && beat_rd[0]) begin
                    dec_pop    = !dec_empty;
                    drop_cnt_d = drop_cnt_q + 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and packet counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Ready is held low while reset is asserted, even though the FIFOs are empty.
    assign s_axis_tready = !beat_full && !rst;
    assign dec_ready     = !dec_full && !rst;

    assign m_axis_tvalid = m_valid;
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = beat_rd;
    assign pass_cnt      = pass_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign data_level    = beat_level;

endmodule

// File: tb/tb_pkt_drop_filter.sv
// Directed, table-driven bench for pkt_drop_filter (DATA_DEPTH=4, DEC_DEPTH=4).
module tb_pkt_drop_filter;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int UW = 128;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    typedef struct {
        int         nb;
        bit         drop;
        logic [1:0] md;
        bit         fwd;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic          dec_valid = 1'b0;
    logic          dec_drop = 1'b0;
    logic          dec_ready;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [31:0]   pass_cnt;
    logic [31:0]   drop_cnt;
    logic [2:0]    data_level;

    always #5 clk = ~clk;

    pkt_drop_filter #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .DATA_DEPTH          (4),
        .DEC_DEPTH           (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .dec_valid    (dec_valid),
        .dec_drop     (dec_drop),
        .dec_ready    (dec_ready),
        .mode         (mode),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .pass_cnt     (pass_cnt),
        .drop_cnt     (drop_cnt),
        .data_level   (data_level)
    );

    int    checks = 0;
    int    errors = 0;
    int    vcount = 0;
    int    ep = 0;
    int    ed = 0;
    beat_t exp_q[$];
    beat_t out_q[$];
    vec_t  tbl[6];

    // Egress monitor, sampled on the falling edge.
    always @(negedge clk) begin
        beat_t mb;
        if (!rst) begin
            if (m_axis_tvalid) vcount++;
            if (m_axis_tvalid && m_axis_tready) begin
                mb = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
                out_q.push_back(mb);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_beat(input string nm, input beat_t got, input beat_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got d=%h k=%h u=%h l=%b expected d=%h k=%h u=%h l=%b",
                     nm, got.d[63:0], got.k, got.u[31:0], got.l,
                     exp.d[63:0], exp.k, exp.u[31:0], exp.l);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t mk(input int pid, input int b, input int n, input logic [63:0] lk);
        beat_t r;
        for (int k = 0; k < 16; k++)
            r.d[k*32 +: 32] = 32'(pid * 65536 + b * 256 + k) ^ 32'h5A00_0000;
        r.k = (b == n - 1) ? lk : '1;
        r.u = {4{32'(32'hC0DE_0000 + pid * 256 + b)}};
        r.l = (b == n - 1);
        return r;
    endfunction

    task automatic push_beat(input beat_t bt);
        bit acc = 0;
        {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = bt;
        s_axis_tvalid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            acc = s_axis_tready;
            step();
            if (acc) break;
        end
        s_axis_tvalid = 1'b0;
        if (!acc) chk("push_beat_timeout", 64'(acc), 64'd1);
    endtask

    task automatic push_dec(input bit d);
        bit acc = 0;
        dec_drop  = d;
        dec_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            acc = dec_ready;
            step();
            if (acc) break;
        end
        dec_valid = 1'b0;
        if (!acc) chk("push_dec_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send_beats(input int pid, input int n, input int first, input int upto,
                              input logic [63:0] lk, input bit fwd);
        beat_t bt;
        for (int b = first; b < upto; b++) begin
            bt = mk(pid, b, n, lk);
            push_beat(bt);
            if (fwd) exp_q.push_back(bt);
        end
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 600; c++) begin
            if (pass_cnt == 32'(ep) && drop_cnt == 32'(ed) && data_level == 3'd0) break;
            step();
        end
        repeat (3) step();
        chk({tag, "_pass_cnt"}, 64'(pass_cnt), 64'(ep));
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(ed));
        chk({tag, "_level"}, 64'(data_level), 64'd0);
    endtask

    task automatic compare_out(input string tag);
        int n;
        chk({tag, "_nbeats"}, 64'(out_q.size()), 64'(exp_q.size()));
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk_beat($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int    v0;
        beat_t b0, b1;
        logic [63:0] lk = 64'h00000000000fffff;

        tbl[0] = '{nb: 2, drop: 1'b1, md: 2'b00, fwd: 1'b0};
        tbl[1] = '{nb: 1, drop: 1'b1, md: 2'b01, fwd: 1'b1};
        tbl[2] = '{nb: 3, drop: 1'b0, md: 2'b10, fwd: 1'b0};
        tbl[3] = '{nb: 1, drop: 1'b0, md: 2'b00, fwd: 1'b1};
        tbl[4] = '{nb: 3, drop: 1'b0, md: 2'b11, fwd: 1'b1};
        tbl[5] = '{nb: 2, drop: 1'b1, md: 2'b11, fwd: 1'b0};

        // Reset held for three cycles.
        rst = 1'b1;
        repeat (3) step();
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_dec_ready", 64'(dec_ready), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_level", 64'(data_level), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_tready", 64'(s_axis_tready), 64'd1);
        chk("post_rst_dec_ready", 64'(dec_ready), 64'd1);
        chk("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("post_rst_pass", 64'(pass_cnt), 64'd0);
        chk("post_rst_drop", 64'(drop_cnt), 64'd0);

        // Latency: beat 0 and decision accepted together in cycle 0.
        b0 = mk(1, 0, 2, lk);
        b1 = mk(1, 1, 2, lk);
        {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = b0;
        s_axis_tvalid = 1'b1;
        dec_valid = 1'b1;
        dec_drop  = 1'b0;
        step();
        dec_valid = 1'b0;
        {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = b1;
        chk("lat_cycle1_tvalid", 64'(m_axis_tvalid), 64'd0);
        step();
        s_axis_tvalid = 1'b0;
        chk("lat_cycle2_tvalid", 64'(m_axis_tvalid), 64'd1);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        ep++;
        drain("pass2");
        compare_out("pass2");

        // Table of packets across drop verdicts and modes.
        for (int i = 0; i < 6; i++) begin
            v0 = vcount;
            mode = tbl[i].md;
            push_dec(tbl[i].drop);
            send_beats(100 + i, tbl[i].nb, 0, tbl[i].nb, lk, tbl[i].fwd);
            if (tbl[i].fwd) ep++; else ed++;
            drain($sformatf("tbl%0d", i));
            compare_out($sformatf("tbl%0d", i));
            if (!tbl[i].fwd) begin
                repeat (300) step();
                chk($sformatf("tbl%0d_no_tvalid", i), 64'(vcount - v0), 64'd0);
            end
        end
        mode = 2'b00;

        // Mode switched to drop-all while a packet is mid-forward.
        m_axis_tready = 1'b0;
        push_dec(1'b0);
        send_beats(200, 3, 0, 3, lk, 1'b1);
        step();
        chk("modesw_fwd_tvalid", 64'(m_axis_tvalid), 64'd1);
        mode = 2'b10;
        m_axis_tready = 1'b1;
        ep++;
        drain("modesw");
        compare_out("modesw");
        mode = 2'b00;

        // Beat buffer fills with no decision, then drains under backpressure.
        send_beats(300, 6, 0, 4, lk, 1'b1);
        chk("full_tready", 64'(s_axis_tready), 64'd0);
        chk("full_level", 64'(data_level), 64'd4);
        repeat (5) step();
        chk("full_tready_hold", 64'(s_axis_tready), 64'd0);
        fork
            push_dec(1'b0);
            send_beats(300, 6, 4, 6, lk, 1'b1);
            begin
                for (int c = 0; c < 40; c++) begin
                    m_axis_tready = ~m_axis_tready;
                    step();
                end
                m_axis_tready = 1'b1;
            end
        join
        ep++;
        drain("bp6");
        compare_out("bp6");

        // Ordering pass/drop/pass, then reset in the middle of packet 3.
        push_dec(1'b0);
        push_dec(1'b1);
        push_dec(1'b0);
        send_beats(401, 2, 0, 2, lk, 1'b1);
        send_beats(402, 2, 0, 2, lk, 1'b0);
        ep++;
        ed++;
        drain("ord12");
        compare_out("ord12");
        m_axis_tready = 1'b0;
        send_beats(403, 3, 0, 2, lk, 1'b0);
        repeat (3) step();
        chk("ord3_pending_tvalid", 64'(m_axis_tvalid), 64'd1);
        rst = 1'b1;
        repeat (2) step();
        chk("midrst_level", 64'(data_level), 64'd0);
        chk("midrst_tready", 64'(s_axis_tready), 64'd0);
        chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        rst = 1'b0;
        m_axis_tready = 1'b1;
        ep = 0;
        ed = 0;
        chk("midrst_pass", 64'(pass_cnt), 64'd0);
        chk("midrst_drop", 64'(drop_cnt), 64'd0);
        repeat (30) step();
        chk("midrst_no_egress", 64'(out_q.size()), 64'd0);
        push_dec(1'b0);
        send_beats(500, 2, 0, 2, lk, 1'b1);
        ep++;
        drain("after_rst");
        compare_out("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
